// File: rtl/vga_timing_controller.sv
// Purpose : 640x480@60 scan timing generator; issues pixelX/pixelY and turns returned RRRGGGBB colour into DAC RGB/sync/blank.
// Latency : coordinates and startOfFrame are undelayed; every DAC-side output lags its coordinate by PIPE_DELAY+1 clocks.
// Backpressure : none; free-running at one pixel per clock, RGB_in is expected PIPE_DELAY clocks after its coordinate.
//
// Ports:
//   clk, reset            pixel clock, asynchronous active-high reset
//   RGB_in[7:0]           {R[2:0],G[2:0],B[1:0]} from the drawing pipeline
//   pixelX/pixelY[10:0]   scan coordinates (driven through blanking too)
//   startOfFrame          one-cycle pulse with coordinate (0,0)
//   red/green/blue[7:0]   bit-replicated DAC colour, zero outside active video
//   hSync, vSync, blankN  delayed sync (polarity SYNC_ACTIVE) and active-video flag
module vga_timing_controller #(
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   PIPE_DELAY  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  RGB_in,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hSync,
    output logic        vSync,
    output logic        blankN
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    generate
        if (PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_bad_pipe_delay
            $error("vga_timing_controller: PIPE_DELAY must be in 1..4");
        end
        if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_totals
            $error("vga_timing_controller: H_TOTAL/V_TOTAL must fit in 11 bits");
        end
    endgenerate

    // Timing bit layout inside the delay line.
    localparam int B_ACT = 0;
    localparam int B_HS  = 1;
    localparam int B_VS  = 2;

    logic [10:0] h_next;
    logic [10:0] v_next;
    logic        started;
    logic [2:0]  raw_timing;
    logic [2:0]  dly [PIPE_DELAY];
    logic [2:0]  dly_out;
    logic [2:0]  r3;
    logic [2:0]  g3;
    logic [1:0]  b2;

    // pixelX/pixelY are themselves the scan counters.
    always_comb begin
        h_next = pixelX + 11'd1;
        v_next = pixelY;
        if (pixelX == H_LAST) begin
            h_next = 11'd0;
            v_next = (pixelY == V_LAST) ? 11'd0 : pixelY + 11'd1;
        end
    end

    // The first edge after reset holds (0,0) and flags startOfFrame;
    // counting starts on the edge after that.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixelX       <= 11'd0;
            pixelY       <= 11'd0;
            startOfFrame <= 1'b0;
            started      <= 1'b0;
        end else if (!started) begin
            started      <= 1'b1;
            startOfFrame <= 1'b1;
        end else begin
            pixelX       <= h_next;
            pixelY       <= v_next;
            startOfFrame <= (h_next == 11'd0) && (v_next == 11'd0);
        end
    end

    // Raw timing in coordinate time. Active is held off until counting has
    // started so the reset-time (0,0) never reaches the DAC as a pixel.
    always_comb begin
        raw_timing        = 3'b000;
        raw_timing[B_ACT] = started && (pixelX < H_ACT) && (pixelY < V_ACT);
        raw_timing[B_HS]  = (pixelX >= HS_FIRST) && (pixelX <= HS_LAST);
        raw_timing[B_VS]  = (pixelY >= VS_FIRST) && (pixelY <= VS_LAST);
    end

    // Delay line matching the drawing pipeline latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE_DELAY; i++) begin
                dly[i] <= 3'b000;
            end
        end else begin
            dly[0] <= raw_timing;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    assign dly_out = dly[PIPE_DELAY-1];

    assign r3 = RGB_in[7:5];
    assign g3 = RGB_in[4:2];
    assign b2 = RGB_in[1:0];

    // Output register: RGB_in is captured on the same edge its timing bits
    // leave the delay line, so colour, sync and blank stay aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            red    <= 8'd0;
            green  <= 8'd0;
            blue   <= 8'd0;
            hSync  <= ~SYNC_ACTIVE;
            vSync  <= ~SYNC_ACTIVE;
            blankN <= 1'b0;
        end else begin
            blankN <= dly_out[B_ACT];
            hSync  <= dly_out[B_HS] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vSync  <= dly_out[B_VS] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            if (dly_out[B_ACT]) begin
                // Bit replication maps full-scale codes to 8'hFF.
                red   <= {r3, r3, r3[2:1]};
                green <= {g3, g3, g3[2:1]};
                blue  <= {b2, b2, b2, b2};
            end else begin
                red   <= 8'd0;
                green <= 8'd0;
                blue  <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_controller.sv
// Purpose : directed bench for vga_timing_controller with two instances.
// Latency : dut_a uses PIPE_DELAY=1 and a short frame (11 lines); dut_b uses PIPE_DELAY=3 and full defaults.
// Backpressure : none; the drawing pipeline is modelled from recorded coordinates.
module tb_vga_timing_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rgb_a, rgb_b;

    logic [10:0] pixelX_a, pixelY_a, pixelX_b, pixelY_b;
    logic        sof_a, sof_b;
    logic [7:0]  red_a, green_a, blue_a, red_b, green_b, blue_b;
    logic        hSync_a, vSync_a, blankN_a, hSync_b, vSync_b, blankN_b;

    always #20 clk = ~clk;

    // Short vertical: V_TOTAL = 4+2+2+3 = 11 lines, 8800 clocks per frame.
    vga_timing_controller #(
        .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIPE_DELAY(1)
    ) dut_a (
        .clk(clk), .reset(reset), .RGB_in(rgb_a),
        .pixelX(pixelX_a), .pixelY(pixelY_a), .startOfFrame(sof_a),
        .red(red_a), .green(green_a), .blue(blue_a),
        .hSync(hSync_a), .vSync(vSync_a), .blankN(blankN_a)
    );

    vga_timing_controller #(
        .PIPE_DELAY(3)
    ) dut_b (
        .clk(clk), .reset(reset), .RGB_in(rgb_b),
        .pixelX(pixelX_b), .pixelY(pixelY_b), .startOfFrame(sof_b),
        .red(red_b), .green(green_b), .blue(blue_b),
        .hSync(hSync_b), .vSync(vSync_b), .blankN(blankN_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] hx [5];        // pixelX_b[7:0] history, hx[0] = this cycle
    logic       prev_act_a;    // activity of dut_a coordinate one cycle ago

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one clock, sample just after the edge, and drive both
    // drawing-pipeline models.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 4; i > 0; i--) hx[i] = hx[i-1];
        hx[0] = pixelX_b[7:0];
        rgb_b = hx[3];
        rgb_a = prev_act_a ? 8'h80 : 8'hFF;
        prev_act_a = (pixelX_a < 11'd640) && (pixelY_a < 11'd4);
    endtask

    task automatic check_reset(input string p);
        check_val({p, "_pix_a"},  {pixelX_a, pixelY_a}, 32'd0);
        check_val({p, "_sof_a"},  sof_a, 32'd0);
        check_val({p, "_rgb_a"},  {red_a, green_a, blue_a}, 32'd0);
        check_val({p, "_sync_a"}, {hSync_a, vSync_a, blankN_a}, 32'b110);
        check_val({p, "_pix_b"},  {pixelX_b, pixelY_b}, 32'd0);
        check_val({p, "_sof_b"},  sof_b, 32'd0);
        check_val({p, "_rgb_b"},  {red_b, green_b, blue_b}, 32'd0);
        check_val({p, "_sync_b"}, {hSync_b, vSync_b, blankN_b}, 32'b110);
    endtask

    int   ex, ey, eyb;
    int   t_h656, t_h752, t_hfall, t_v6, t_vfall, t_bra, t_brb, t_x0a, t_x0b, t_sof, rises;
    logic p_hs, p_vs, p_bn_a, p_bn_b;
    logic found;

    initial begin
        reset = 1'b1;
        rgb_a = 8'h00;
        rgb_b = 8'h00;
        prev_act_a = 1'b0;
        for (int i = 0; i < 5; i++) hx[i] = 8'h00;

        step();
        step();
        step();
        check_reset("rst");

        // Release mid-cycle; first edge holds (0,0) with startOfFrame.
        reset = 1'b0;
        step();
        check_val("rel1_pix_a", {pixelX_a, pixelY_a}, 32'd0);
        check_val("rel1_sof_a", sof_a, 32'd1);
        check_val("rel1_pix_b", {pixelX_b, pixelY_b}, 32'd0);
        check_val("rel1_sof_b", sof_b, 32'd1);
        t_x0a = cyc;
        t_x0b = cyc;
        t_sof = cyc;
        step();
        check_val("rel2_pix_a", {pixelX_a, pixelY_a}, {11'd1, 11'd0});
        check_val("rel2_sof_a", sof_a, 32'd0);
        check_val("rel2_pix_b", {pixelX_b, pixelY_b}, {11'd1, 11'd0});
        check_val("rel2_sof_b", sof_b, 32'd0);

        ex = 1; ey = 0; eyb = 0;
        t_h656 = -10000; t_h752 = -10000; t_hfall = -10000; t_v6 = -10000;
        t_vfall = -10000; t_bra = -10000; t_brb = -10000; rises = 0;
        p_hs = hSync_a; p_vs = vSync_a; p_bn_a = blankN_a; p_bn_b = blankN_b;

        // Two full short frames of dut_a; dut_b covers ~22 active lines.
        for (int n = 0; n < 17610; n++) begin
            step();
            if (ex == 799) begin
                ex  = 0;
                ey  = (ey == 10) ? 0 : ey + 1;
                eyb = (eyb == 524) ? 0 : eyb + 1;
            end else begin
                ex++;
            end
            check_val("coord_a", {pixelX_a, pixelY_a}, {11'(ex), 11'(ey)});
            check_val("sof_a",   sof_a, {31'd0, (ex == 0 && ey == 0)});
            check_val("coord_b", {pixelX_b, pixelY_b}, {11'(ex), 11'(eyb)});
            check_val("sof_b",   sof_b, {31'd0, (ex == 0 && eyb == 0)});

            if (pixelX_a == 11'd656) t_h656 = cyc;
            if (pixelX_a == 11'd752) t_h752 = cyc;
            if (pixelX_a == 11'd0) t_x0a = cyc;
            if (pixelX_a == 11'd0 && pixelY_a == 11'd6) t_v6 = cyc;
            if (pixelX_b == 11'd0) t_x0b = cyc;

            if (p_hs && !hSync_a) begin
                check_val("hs_fall_lag", cyc - t_h656, 32'd2);
                t_hfall = cyc;
            end
            if (!p_hs && hSync_a) begin
                check_val("hs_rise_lag", cyc - t_h752, 32'd2);
                check_val("hs_width", cyc - t_hfall, 32'd96);
            end
            if (p_vs && !vSync_a) begin
                check_val("vs_fall_lag", cyc - t_v6, 32'd2);
                t_vfall = cyc;
            end
            if (!p_vs && vSync_a) check_val("vs_width", cyc - t_vfall, 32'd1600);

            if (!p_bn_a && blankN_a) begin
                check_val("bn_rise_a", cyc - t_x0a, 32'd2);
                t_bra = cyc;
                rises++;
            end
            if (p_bn_a && !blankN_a) check_val("bn_width_a", cyc - t_bra, 32'd640);
            if (sof_a) begin
                check_val("sof_period", cyc - t_sof, 32'd8800);
                check_val("bn_lines", rises, 32'd4);
                t_sof = cyc;
                rises = 0;
            end

            if (blankN_a) check_val("rgb_act_a", {red_a, green_a, blue_a}, 32'h920000);
            else          check_val("rgb_blank_a", {red_a, green_a, blue_a}, 32'd0);

            if (!p_bn_b && blankN_b) begin
                check_val("bn_rise_b", cyc - t_x0b, 32'd4);
                t_brb = cyc;
            end
            if (p_bn_b && !blankN_b) check_val("bn_width_b", cyc - t_brb, 32'd640);
            if (blankN_b) check_val("align_b", {red_b[7:5], green_b[7:5], blue_b[7:6]}, {24'd0, hx[4]});
            else          check_val("rgb_blank_b", {red_b, green_b, blue_b}, 32'd0);

            p_hs = hSync_a; p_vs = vSync_a; p_bn_a = blankN_a; p_bn_b = blankN_b;
        end

        // Mid-line reset while dut_a's hSync output is asserted.
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            step();
            if (pixelX_a == 11'd700) found = 1'b1;
        end
        check_val("find_x700", found, 32'd1);
        check_val("pre_rst_hs_a", hSync_a, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check_reset("async");
        step();
        step();
        check_reset("held");
        reset = 1'b0;
        step();
        check_val("rel3_pix_a", {pixelX_a, pixelY_a}, 32'd0);
        check_val("rel3_sof_a", sof_a, 32'd1);
        check_val("rel3_pix_b", {pixelX_b, pixelY_b}, 32'd0);
        step();
        check_val("rel4_pix_a", {pixelX_a, pixelY_a}, {11'd1, 11'd0});
        check_val("rel4_sof_a", sof_a, 32'd0);
        check_val("rel4_sof_b", sof_b, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
